// File: rtl/adder_share_ctrl_if.sv
// Request/response bundle between requesters and the shared-adder controller.
// The master side issues requests and consumes results; the slave side is the controller.
interface adder_share_ctrl_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_cin;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_sum;
  logic                     rsp_cout;

  modport master (
    output req_valid, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );
endinterface

// File: rtl/adder_share_ctrl.sv
// Round-robin sharing of one external combinational adder between NUM_REQ requesters.
// state  | meaning
// IDLE   | waiting for a request; grant is combinational from rr_ptr
// SETTLE | operands registered on add_*, counting down the carry-ripple budget
// RESP   | sum captured, holding rsp_* until the consumer takes it
module adder_share_ctrl #(
  parameter int NUM_REQ       = 4,
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 2,
  parameter int ID_W          = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  adder_share_ctrl_if.slave   bus,
  output logic                busy,
  output logic [WIDTH-1:0]    add_x,
  output logic [WIDTH-1:0]    add_y,
  output logic                add_ci,
  input  logic [WIDTH-1:0]    add_s,
  input  logic                add_co
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  state_t             state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    grant_id;
  logic [CNT_W-1:0]   cnt;
  logic [ID_W-1:0]    gnt;
  logic               gnt_found;
  logic [ID_W:0]      cand_wide;
  logic [ID_W-1:0]    cand;
  logic [NUM_REQ-1:0] ready_vec;
  logic               rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [WIDTH-1:0]   rsp_sum_q;
  logic               rsp_cout_q;

  // Walk offsets from farthest to nearest so the nearest valid index from rr_ptr wins.
  always_comb begin
    gnt       = '0;
    gnt_found = 1'b0;
    cand_wide = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_wide = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (cand_wide >= (ID_W+1)'(NUM_REQ)) cand_wide = cand_wide - (ID_W+1)'(NUM_REQ);
      cand = cand_wide[ID_W-1:0];
      if (bus.req_valid[cand]) begin
        gnt       = cand;
        gnt_found = 1'b1;
      end
    end
  end

  always_comb begin
    ready_vec = '0;
    if (state == IDLE && gnt_found) ready_vec[gnt] = 1'b1;
  end

  assign bus.req_ready = ready_vec;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      cnt         <= '0;
      add_x       <= '0;
      add_y       <= '0;
      add_ci      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            add_x    <= bus.req_a[gnt*WIDTH +: WIDTH];
            add_y    <= bus.req_b[gnt*WIDTH +: WIDTH];
            add_ci   <= bus.req_cin[gnt];
            grant_id <= gnt;
            rr_ptr   <= (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
            cnt      <= CNT_W'(SETTLE_CYCLES);
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            rsp_sum_q   <= add_s;
            rsp_cout_q  <= add_co;
            rsp_id_q    <= grant_id;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Randomized bench for adder_share_ctrl with a transaction-level reference model
// and a behavioural adder standing in for the external ripple adder.
module tb_adder_share_ctrl;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int S  = 2;
  localparam int IW = 2;

  logic         clk;
  logic         rst_n;
  logic         busy;
  logic [W-1:0] add_x, add_y, add_s;
  logic         add_ci, add_co;

  adder_share_ctrl_if #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) bus ();

  adder_share_ctrl #(.NUM_REQ(N), .WIDTH(W), .SETTLE_CYCLES(S), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy),
    .add_x(add_x), .add_y(add_y), .add_ci(add_ci), .add_s(add_s), .add_co(add_co)
  );

  assign {add_co, add_s} = {1'b0, add_x} + {1'b0, add_y} + (W+1)'(add_ci);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;
  int dut_grants[$];
  logic [N-1:0] ready_neg = '0;

  // reference model: transaction phase 0=idle, 1=adding, 2=holding result
  int           m_phase = 0;
  int           m_left  = 0;
  int           m_ptr   = 0;
  int           m_id    = 0;
  logic [W-1:0] m_x     = '0;
  logic [W-1:0] m_y     = '0;
  logic         m_ci    = 1'b0;
  logic [W:0]   m_res   = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int first_req(input logic [N-1:0] v, input int ptr);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (ptr + k) % N;
      if (((v >> idx) & N'(1)) != '0) return idx;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    int g;
    g = -1;
    for (int i = 0; i < N; i++) if (((v >> i) & N'(1)) != '0) g = i;
    return g;
  endfunction

  function automatic logic [W-1:0] rnd();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  initial forever begin
    int g;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = 0; m_left = 0; m_ptr = 0; m_id = 0;
      m_x = '0; m_y = '0; m_ci = 1'b0; m_res = '0;
    end else if (m_phase == 0) begin
      g = first_req(bus.req_valid, m_ptr);
      if (g >= 0) begin
        m_x   = W'(bus.req_a >> (g * W));
        m_y   = W'(bus.req_b >> (g * W));
        m_ci  = 1'(bus.req_cin >> g);
        m_res = {1'b0, m_x} + {1'b0, m_y} + (W+1)'(m_ci);
        m_id  = g;
        m_ptr = (g + 1) % N;
        m_left = S;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_left--;
      if (m_left == 0) m_phase = 2;
    end else if (bus.rsp_ready) begin
      m_phase = 0;
    end
  end

  initial forever begin
    int g;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    ready_neg = bus.req_ready;
    if (rst_n) begin
      exp_ready = '0;
      if (m_phase == 0) begin
        g = first_req(bus.req_valid, m_ptr);
        if (g >= 0) exp_ready = N'(1) << g;
      end
      chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
      chk("busy", 64'(busy), 64'(m_phase != 0));
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_phase == 2));
      chk("add_ops", {31'(0), add_ci, add_x}, {31'(0), m_ci, m_x});
      chk("add_y", 64'(add_y), 64'(m_y));
      if (m_phase == 2) begin
        chk("rsp_id", 64'(bus.rsp_id), 64'(m_id));
        chk("rsp_sum_cout", 64'({bus.rsp_cout, bus.rsp_sum}), 64'(m_res));
      end
      if (bus.req_ready != '0) dut_grants.push_back(onehot_idx(bus.req_ready));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic ci);
    logic [N*W-1:0] m;
    m = (N*W)'({W{1'b1}}) << (i * W);
    bus.req_a     = (bus.req_a & ~m) | ((N*W)'(a) << (i * W));
    bus.req_b     = (bus.req_b & ~m) | ((N*W)'(b) << (i * W));
    bus.req_valid = (bus.req_valid & ~(N'(1) << i)) | (N'(v) << i);
    bus.req_cin   = (bus.req_cin & ~(N'(1) << i)) | (N'(ci) << i);
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int t = 0; t < 50; t++) begin
      if (!busy) begin ok = 1; break; end
      tick();
    end
    chk("drain_timeout", 64'(ok), 64'(1));
  endtask

  task automatic single(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic [W:0] exp);
    bit ok;
    int n;
    set_req(id, 1'b1, a, b, ci);
    ok = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin ok = 1; break; end
    end
    chk("single_grant_timeout", 64'(ok), 64'(1));
    chk("single_ready_onehot", 64'(bus.req_ready), 64'(N'(1) << id));
    tick();
    set_req(id, 1'b0, '0, '0, 1'b0);
    n = 0;
    ok = 0;
    for (int t = 0; t < 20; t++) begin
      if (bus.rsp_valid) begin ok = 1; break; end
      tick();
      n++;
    end
    chk("single_rsp_timeout", 64'(ok), 64'(1));
    chk("single_latency", 64'(n), 64'(S));
    chk("single_sum", 64'(bus.rsp_sum), 64'(exp[W-1:0]));
    chk("single_cout", 64'(bus.rsp_cout), 64'(exp[W]));
    chk("single_id", 64'(bus.rsp_id), 64'(id));
    tick();
  endtask

  initial begin
    bit ok;
    int exp_ord[5];
    int snap_id;
    logic [W-1:0] snap_sum, snap_x;
    logic snap_cout;
    bit vi, ri;

    exp_ord = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_cin = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'(0));
    chk("rst_rsp_sum", 64'(bus.rsp_sum), 64'(0));
    chk("rst_rsp_cout", 64'(bus.rsp_cout), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
    chk("rst_add", {31'(0), add_ci, add_x}, 64'(0));
    chk("rst_add_y", 64'(add_y), 64'(0));
    rst_n = 1'b1;
    tick();

    single(0, 32'h0000_0001, 32'h0000_0001, 1'b0, 33'h0_0000_0002);
    single(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33'h1_0000_0000);
    single(3, 32'h1234_5678, 32'h8765_4321, 1'b1, 33'h0_9999_999A);

    // all requesters continuously valid: rotation check
    dut_grants.delete();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, rnd(), rnd(), 1'($urandom_range(0, 1)));
    ok = 0;
    for (int t = 0; t < 200; t++) begin
      tick();
      if (dut_grants.size() >= 5) begin ok = 1; break; end
    end
    for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0, 1'b0);
    chk("rotation_timeout", 64'(ok), 64'(1));
    for (int i = 0; i < 5; i++)
      if (i < dut_grants.size()) chk("rotation_order", 64'(dut_grants[i]), 64'(exp_ord[i]));
    drain();

    // back-pressure in RESP with other requests pending
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, rnd(), rnd(), 1'($urandom_range(0, 1)));
    ok = 0;
    for (int t = 0; t < 50; t++) begin
      tick();
      if (bus.rsp_valid) begin ok = 1; break; end
    end
    chk("bp_rsp_timeout", 64'(ok), 64'(1));
    snap_id = int'(bus.rsp_id); snap_sum = bus.rsp_sum; snap_cout = bus.rsp_cout; snap_x = add_x;
    repeat (5) begin
      tick();
      chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'(1));
      chk("bp_rsp_stable", {31'(0), bus.rsp_cout, bus.rsp_sum}, {31'(0), snap_cout, snap_sum});
      chk("bp_rsp_id", 64'(bus.rsp_id), 64'(snap_id));
      chk("bp_req_ready", 64'(bus.req_ready), 64'(0));
      chk("bp_busy", 64'(busy), 64'(1));
      chk("bp_add_x", 64'(add_x), 64'(snap_x));
    end
    dut_grants.delete();
    bus.rsp_ready = 1'b1;
    tick();
    ok = 0;
    for (int t = 0; t < 10; t++) begin
      if (dut_grants.size() >= 1) begin ok = 1; break; end
      tick();
    end
    for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0, 1'b0);
    chk("bp_next_timeout", 64'(ok), 64'(1));
    if (dut_grants.size() >= 1) chk("bp_next_grant", 64'(dut_grants[0]), 64'((snap_id + 1) % N));
    drain();

    // reset in the middle of SETTLE
    set_req(3, 1'b1, rnd(), 32'h0000_0005, 1'b1);
    ok = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (busy) begin ok = 1; break; end
    end
    chk("mid_rst_grant_timeout", 64'(ok), 64'(1));
    set_req(3, 1'b0, '0, '0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("async_busy", 64'(busy), 64'(0));
    chk("async_rsp_sum", 64'(bus.rsp_sum), 64'(0));
    chk("async_add_x", 64'(add_x), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    dut_grants.delete();
    set_req(1, 1'b1, rnd(), rnd(), 1'b0);
    set_req(2, 1'b1, rnd(), rnd(), 1'b1);
    ok = 0;
    for (int t = 0; t < 10; t++) begin
      if (dut_grants.size() >= 1) begin ok = 1; break; end
      tick();
    end
    chk("post_rst_timeout", 64'(ok), 64'(1));
    if (dut_grants.size() >= 1) chk("post_rst_first_grant", 64'(dut_grants[0]), 64'(1));
    for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0, 1'b0);
    drain();

    // randomized traffic honouring the requester protocol
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        vi = ((bus.req_valid >> i) & N'(1)) != '0;
        ri = ((ready_neg >> i) & N'(1)) != '0;
        if (vi && !ri) begin
          if ($urandom_range(0, 15) == 0) set_req(i, 1'b0, '0, '0, 1'b0);
        end else if ($urandom_range(0, 2) == 0) begin
          set_req(i, 1'b1, rnd(), rnd(), 1'($urandom_range(0, 1)));
        end else begin
          set_req(i, 1'b0, '0, '0, 1'b0);
        end
      end
      bus.rsp_ready = 1'($urandom_range(0, 1));
      tick();
    end
    for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0, 1'b0);
    bus.rsp_ready = 1'b1;
    drain();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_share_ctrl.md
Name: adder_share_ctrl

Overview:
- Shares one combinational ripple_adder (WIDTH-bit, ports X/Y/Ci/S/Co) between NUM_REQ requesters.
- Arbitration is round-robin. The block registers the adder operands and holds them for a fixed settle budget, then captures the sum and returns it with the requester ID.
- Only one addition is in flight at a time. The adder instance sits outside this block and connects through the add_* ports.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- WIDTH, 32, operand/sum width; must match the adder instance.
- SETTLE_CYCLES, 2, clock cycles allowed for carry ripple before the sum is sampled (>=1).
- ID_W, 2, width of requester index; equals clog2(NUM_REQ).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_a  in  NUM_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  operand B, same packing.
- req_cin  in  NUM_REQ  carry-in per requester.
- req_ready  out  NUM_REQ  one-hot accept strobe.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumer ready.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_sum  out  WIDTH  captured sum.
- rsp_cout  out  1  captured carry-out.
- busy  out  1  high whenever the FSM is not in IDLE.
- add_x  out  WIDTH  registered operand to adder X.
- add_y  out  WIDTH  registered operand to adder Y.
- add_ci  out  1  registered carry to adder Ci.
- add_s  in  WIDTH  adder sum S.
- add_co  in  1  adder carry-out Co.

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE, rr_ptr=0, settle counter=0.
  - add_x=0, add_y=0, add_ci=0.
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0.
  - busy=0, req_ready=0.
- States: IDLE, SETTLE, RESP.
- IDLE:
  - Grant is combinational: the first i with req_valid[i]=1, searching from rr_ptr upward with wrap mod NUM_REQ.
  - req_ready[g]=1 only for the granted index, only in IDLE, only while req_valid[g]=1. It is zero in every other state.
  - At the accepting edge: add_x<=req_a[g], add_y<=req_b[g], add_ci<=req_cin[g], grant_id<=g, rr_ptr<=(g+1) mod NUM_REQ, counter<=SETTLE_CYCLES, go to SETTLE.
  - No request valid: stay in IDLE; rr_ptr is unchanged.
- SETTLE:
  - Counter decrements each edge.
  - At the edge where counter==1: rsp_sum<=add_s, rsp_cout<=add_co, rsp_id<=grant_id, rsp_valid<=1, go to RESP.
  - Net effect: rsp_valid is high starting exactly SETTLE_CYCLES edges after the accepting edge.
- RESP:
  - rsp_valid, rsp_id, rsp_sum and rsp_cout are held stable until rsp_valid&&rsp_ready at an edge.
  - On that edge: rsp_valid<=0, go to IDLE. The next grant happens no earlier than the following cycle.
- Operand stability: add_x, add_y and add_ci change only at accepting edges. They hold their value through RESP and IDLE; they are not cleared.
- Requester protocol: a requester must hold valid and data stable until it sees req_ready. Dropping req_valid before the grant is legal and simply withdraws the request.
- Arithmetic: the block performs no arithmetic itself. The result is whatever the adder drives, i.e. {cout,sum} = a+b+cin modulo 2^(WIDTH+1).
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ transactions.
- Simultaneous events: rsp_ready arriving in SETTLE has no effect. New req_valid arriving in SETTLE or RESP is ignored until the next IDLE cycle.
- Reset mid-operation: all state clears immediately (asynchronously), the in-flight transaction is dropped with no response, and rr_ptr returns to 0.

Test Plan:
1. req_valid=0001, A=00000001, B=00000001, cin=0, SETTLE_CYCLES=2, rsp_ready=1 -> req_ready=0001 for one cycle; rsp_valid high 2 edges later with sum=00000002, cout=0, id=0.
2. Requester 2 sends FFFFFFFF+00000001, cin=0 -> sum=00000000, cout=1, id=2.
3. Requester 3 sends 12345678+87654321, cin=1 -> sum=9999999A, cout=0, id=3.
4. All four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0; each response carries that requester's operands; never two req_ready bits high at once.
5. rsp_ready held 0 for 5 cycles in RESP with other requests pending -> rsp_* stable, req_ready=0000, busy=1, add_x unchanged; raising rsp_ready completes the handshake, and the next grant goes to the next requester in rotation.
6. rst_n pulsed low during SETTLE, then req_valid=0110 after release -> rsp_valid=0, busy=0 and rsp_sum=0 asynchronously, no stale response appears, first grant after release goes to requester 1.
